// File: rtl/cache_mem_tester_pkg.sv
// Shared definitions for the cache memory tester: state encoding,
// word size and the deterministic test pattern.
package cache_mem_tester_pkg;

   // Bytes per cache word; the address advances by this much per index.
   localparam int unsigned WORD_BYTES = 4;

   // Tester states. The 4-bit encoding is exported on the status LEDs,
   // so the values are fixed explicitly.
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_WR_ISSUE  = 4'd1,
      ST_WR_WAIT   = 4'd2,
      ST_RD_SETUP  = 4'd3,
      ST_RD_SETTLE = 4'd4,
      ST_RD_WAIT   = 4'd5,
      ST_DONE      = 4'd6
   } state_t;

   // Pattern word for a byte address: low address half and its complement,
   // scrambled with the seed. Only the low 16 address bits contribute.
   function automatic logic [31:0] pat(input logic [15:0] addr_lo,
                                       input logic [31:0] seed);
      return {addr_lo, ~addr_lo} ^ seed;
   endfunction

endpackage

// File: rtl/cache_mem_tester_if.sv
// Word port between the tester (master) and the PSRAM-backed cache (slave).
//
// Handshake: a write is accepted on a rising clk edge where write_enable is
// non-zero and busy is 0. A read result is valid on any cycle where
// data_out_ready is 1 and busy is 0; data_out_ready drops for at least one
// cycle after address changes, so a reader must not trust it on the first
// cycle after moving the address.
interface cache_mem_tester_if;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [3:0]  write_enable;
   logic [31:0] data_out;
   logic        data_out_ready;
   logic        busy;

   modport master (
      output address,
      output data_in,
      output write_enable,
      input  data_out,
      input  data_out_ready,
      input  busy
   );

   modport slave (
      input  address,
      input  data_in,
      input  write_enable,
      output data_out,
      output data_out_ready,
      output busy
   );
endinterface

// File: rtl/cache_mem_tester.sv
// Self-checking traffic source for the cache word port: writes a pattern
// over a word range, reads it back, and reports pass/fail, an error count
// and the first failing address.
module cache_mem_tester
   import cache_mem_tester_pkg::*;
#(
   parameter logic [31:0] ADDR_START = 32'h0000_0000,
   parameter int unsigned WORD_COUNT = 1024,
   parameter logic [31:0] SEED       = 32'hA5A5_5A5A
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   cache_mem_tester_if.master        cache,
   output logic                      done,
   output logic                      pass,
   output logic [15:0]               error_count,
   output logic [31:0]               first_error_addr,
   output logic [5:0]                status
);

   localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);
   localparam logic [31:0] STEP     = 32'(WORD_BYTES);

   state_t      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic [31:0] addr_q, addr_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [15:0] err_q, err_d;
   logic [31:0] first_q, first_d;

   logic [31:0] expected;
   logic        read_valid;
   logic        mismatch;
   logic        last_word;
   logic [15:0] err_inc;

   assign expected   = pat(addr_q[15:0], SEED);
   assign read_valid = cache.data_out_ready && !cache.busy;
   assign mismatch   = (cache.data_out != expected);
   assign last_word  = (idx_q == LAST_IDX);
   assign err_inc    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

   // State and datapath registers; reset aborts any run immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         first_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         first_q <= first_d;
      end
   end

   // Next-state and datapath update for the write-then-verify sequence.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      first_d = first_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_WR_ISSUE;
               idx_d   = '0;
               addr_d  = ADDR_START;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               first_d = '0;
            end
         end

         // The strobe is only visible while busy is low, so leaving here
         // coincides with the single accepted write cycle.
         ST_WR_ISSUE: begin
            if (!cache.busy) begin
               state_d = ST_WR_WAIT;
            end
         end

         ST_WR_WAIT: begin
            if (!cache.busy) begin
               if (last_word) begin
                  state_d = ST_RD_SETUP;
                  idx_d   = '0;
                  addr_d  = ADDR_START;
               end else begin
                  state_d = ST_WR_ISSUE;
                  idx_d   = idx_q + 16'd1;
                  addr_d  = addr_q + STEP;
               end
            end
         end

         ST_RD_SETUP: begin
            state_d = ST_RD_SETTLE;
         end

         // Fixed dead cycle so a ready flag left over from the previous
         // address cannot be mistaken for this word's data.
         ST_RD_SETTLE: begin
            state_d = ST_RD_WAIT;
         end

         ST_RD_WAIT: begin
            if (read_valid) begin
               if (mismatch) begin
                  err_d = err_inc;
                  if (err_q == 16'd0) begin
                     first_d = addr_q;
                  end
               end
               if (last_word) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_q == 16'd0) && !mismatch;
               end else begin
                  state_d = ST_RD_SETUP;
                  idx_d   = idx_q + 16'd1;
                  addr_d  = addr_q + STEP;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Cache port drive: address is registered, strobe and data only in WR_ISSUE.
   always_comb begin
      cache.address      = addr_q;
      cache.data_in      = '0;
      cache.write_enable = 4'b0000;
      if (state_q == ST_WR_ISSUE) begin
         cache.data_in = expected;
         if (!cache.busy) begin
            cache.write_enable = 4'b1111;
         end
      end
   end

   assign done             = done_q;
   assign pass             = pass_q;
   assign error_count      = err_q;
   assign first_error_addr = first_q;
   assign status           = {cache.busy, cache.data_out_ready, state_q};

endmodule

// File: tb/tb_cache_mem_tester.sv
// Directed bench for cache_mem_tester with a behavioural cache model.
module tb_cache_mem_tester;
   import cache_mem_tester_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT A: 4 words at 0x0, full cache model ----------------
   cache_mem_tester_if bus_a ();
   logic        done_a, pass_a;
   logic [15:0] errs_a;
   logic [31:0] first_a;
   logic [5:0]  status_a;

   cache_mem_tester #(.ADDR_START(32'h0), .WORD_COUNT(4), .SEED(32'hA5A5_5A5A)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .cache(bus_a.master),
      .done(done_a), .pass(pass_a), .error_count(errs_a),
      .first_error_addr(first_a), .status(status_a)
   );

   logic [31:0] mem_a [16];
   logic [31:0] prev_a;
   logic [3:0]  busy_cnt;
   logic [27:0] cur_line;
   logic        stall_en = 1'b0;
   logic        corrupt_en = 1'b0;
   logic [31:0] corrupt_addr = 32'h8;

   assign bus_a.busy           = (busy_cnt != 4'd0);
   assign bus_a.data_out_ready = (bus_a.address == prev_a);
   assign bus_a.data_out       = mem_a[bus_a.address[5:2]] ^
                                 ((corrupt_en && bus_a.address == corrupt_addr) ? 32'h1 : 32'h0);

   // Cache model A: writes, random/line-miss busy stalls, ready drop on address change.
   always @(posedge clk) begin
      prev_a <= bus_a.address;
      if (rst) begin
         busy_cnt <= 4'd0;
         cur_line <= '0;
         for (int k = 0; k < 16; k++) mem_a[k] <= '0;
      end else begin
         if (bus_a.write_enable == 4'hF && busy_cnt == 4'd0)
            mem_a[bus_a.address[5:2]] <= bus_a.data_in;
         if (busy_cnt != 4'd0)
            busy_cnt <= busy_cnt - 4'd1;
         else if (stall_en && (bus_a.address[31:4] != cur_line || $urandom_range(0, 2) == 0)) begin
            busy_cnt <= 4'($urandom_range(1, 8));
            cur_line <= bus_a.address[31:4];
         end
      end
   end

   // Scoreboard of expected writes {address, data}, in issue order.
   logic [63:0] exp_q[$];
   logic [63:0] exp_w;

   // Write monitor: strobe never under busy, one strobe per expected word.
   always @(negedge clk) begin
      if (!rst && bus_a.write_enable != 4'h0) begin
         checks++;
         if (bus_a.busy || bus_a.write_enable != 4'hF) begin
            errors++;
            $display("FAIL wr_strobe got we=%h busy=%b want we=f busy=0",
                     bus_a.write_enable, bus_a.busy);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_extra got addr 0x%08h want no strobe", bus_a.address);
         end else begin
            exp_w = exp_q.pop_front();
            if ({bus_a.address, bus_a.data_in} !== exp_w) begin
               errors++;
               $display("FAIL wr_word got %h_%h want %h_%h", bus_a.address, bus_a.data_in,
                        exp_w[63:32], exp_w[31:0]);
            end
         end
      end
   end

   // ---------------- DUT B: 3 words at 0x100, cache always returns 0 ----------------
   cache_mem_tester_if bus_b ();
   logic        done_b, pass_b;
   logic [15:0] errs_b;
   logic [31:0] first_b;
   logic [5:0]  status_b;
   logic [31:0] prev_b;

   cache_mem_tester #(.ADDR_START(32'h100), .WORD_COUNT(3), .SEED(32'hA5A5_5A5A)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .cache(bus_b.master),
      .done(done_b), .pass(pass_b), .error_count(errs_b),
      .first_error_addr(first_b), .status(status_b)
   );

   assign bus_b.busy           = 1'b0;
   assign bus_b.data_out       = 32'h0;
   assign bus_b.data_out_ready = (bus_b.address == prev_b);

   // Cache model B: only tracks the address for the ready drop.
   always @(posedge clk) prev_b <= bus_b.address;

   // ---------------- helpers ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_vec_t;

   typedef struct {
      logic        stall;
      logic        corrupt;
      logic        exp_pass;
      logic [15:0] exp_errs;
      logic [31:0] exp_first;
   } run_vec_t;

   wr_vec_t  wr_tab [4];
   run_vec_t runs   [3];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got 0x%08h want 0x%08h", name, got, want);
      end
   endtask

   task automatic load_exp();
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back({wr_tab[k].addr, wr_tab[k].data});
   endtask

   task automatic pulse_start_a();
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int max_cycles);
      int n = 0;
      while (!done_a && n < max_cycles) begin
         @(negedge clk); n++;
      end
      chk("done_a_timeout", {31'd0, done_a}, 32'd1);
   endtask

   task automatic wait_state_a(input state_t st, input logic [31:0] addr, input int max_cycles);
      int n = 0;
      while (!(status_a[3:0] == st && bus_a.address == addr) && n < max_cycles) begin
         @(negedge clk); n++;
      end
      chk("wait_state_timeout", {28'd0, status_a[3:0]}, {28'd0, st});
   endtask

   // ---------------- test sequence ----------------
   initial begin
      wr_tab[0] = '{32'h0000_0000, 32'hA5A5_A5A5};
      wr_tab[1] = '{32'h0000_0004, 32'hA5A1_A5A1};
      wr_tab[2] = '{32'h0000_0008, 32'hA5AD_A5AD};
      wr_tab[3] = '{32'h0000_000C, 32'hA5A9_A5A9};

      runs[0] = '{1'b0, 1'b0, 1'b1, 16'd0, 32'h0};
      runs[1] = '{1'b1, 1'b0, 1'b1, 16'd0, 32'h0};
      runs[2] = '{1'b1, 1'b1, 1'b0, 16'd1, 32'h8};

      // Reset: every output zero, both instances idle.
      repeat (3) @(negedge clk);
      chk("rst_address", bus_a.address, 32'h0);
      chk("rst_data_in", bus_a.data_in, 32'h0);
      chk("rst_we", {28'd0, bus_a.write_enable}, 32'h0);
      chk("rst_done", {31'd0, done_a}, 32'h0);
      chk("rst_pass", {31'd0, pass_a}, 32'h0);
      chk("rst_errs", {16'd0, errs_a}, 32'h0);
      chk("rst_first", first_a, 32'h0);
      chk("rst_state", {28'd0, status_a[3:0]}, 32'h0);
      chk("rst_b_address", bus_b.address, 32'h0);
      rst = 1'b0;

      // Table-driven runs: clean, stalled, stalled with a corrupted word.
      for (int r = 0; r < 3; r++) begin
         stall_en     = runs[r].stall;
         corrupt_en   = runs[r].corrupt;
         corrupt_addr = 32'h8;
         load_exp();
         pulse_start_a();
         if (!runs[r].stall)
            chk("first_write_latency", {28'd0, bus_a.write_enable}, 32'hF);
         wait_done_a(3000);
         chk("run_done", {31'd0, done_a}, 32'd1);
         chk("run_pass", {31'd0, pass_a}, {31'd0, runs[r].exp_pass});
         chk("run_errs", {16'd0, errs_a}, {16'd0, runs[r].exp_errs});
         chk("run_first", first_a, runs[r].exp_first);
         chk("run_state", {28'd0, status_a[3:0]}, {28'd0, ST_DONE});
         chk("run_writes_left", exp_q.size(), 32'd0);
      end

      // All reads return zero on a 3-word range starting at 0x100.
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      begin
         int n = 0;
         while (!done_b && n < 200) begin
            @(negedge clk); n++;
         end
      end
      chk("zero_done", {31'd0, done_b}, 32'd1);
      chk("zero_pass", {31'd0, pass_b}, 32'd0);
      chk("zero_errs", {16'd0, errs_b}, 32'd3);
      chk("zero_first", first_b, 32'h100);

      // Reset in the read phase at i=2, after an error was counted at 0x4.
      stall_en     = 1'b0;
      corrupt_en   = 1'b1;
      corrupt_addr = 32'h4;
      load_exp();
      pulse_start_a();
      wait_state_a(ST_RD_SETUP, 32'h8, 200);
      chk("pre_rst_errs", {16'd0, errs_a}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_we", {28'd0, bus_a.write_enable}, 32'h0);
      chk("midrst_done", {31'd0, done_a}, 32'h0);
      chk("midrst_errs", {16'd0, errs_a}, 32'h0);
      chk("midrst_first", first_a, 32'h0);
      chk("midrst_state", {28'd0, status_a[3:0]}, {28'd0, ST_IDLE});
      chk("midrst_address", bus_a.address, 32'h0);
      @(negedge clk); rst = 1'b0;
      corrupt_en = 1'b0;
      load_exp();
      pulse_start_a();
      wait_done_a(300);
      chk("rerun_pass", {31'd0, pass_a}, 32'd1);
      chk("rerun_errs", {16'd0, errs_a}, 32'd0);

      // Start in RD_WAIT is ignored; start after DONE clears and reruns.
      corrupt_en   = 1'b1;
      corrupt_addr = 32'h8;
      load_exp();
      pulse_start_a();
      wait_state_a(ST_RD_WAIT, 32'hC, 200);
      start_a = 1'b1;
      @(posedge clk); #1;
      chk("ign_state", {28'd0, status_a[3:0]}, {28'd0, ST_DONE});
      chk("ign_done", {31'd0, done_a}, 32'd1);
      chk("ign_errs", {16'd0, errs_a}, 32'd1);
      chk("ign_first", first_a, 32'h8);
      @(negedge clk); start_a = 1'b0;
      chk("ign_pass", {31'd0, pass_a}, 32'd0);
      corrupt_en = 1'b0;
      load_exp();
      pulse_start_a();
      chk("restart_errs", {16'd0, errs_a}, 32'd0);
      chk("restart_done", {31'd0, done_a}, 32'd0);
      chk("restart_first", first_a, 32'h0);
      wait_done_a(300);
      chk("second_pass", {31'd0, pass_a}, 32'd1);
      chk("second_errs", {16'd0, errs_a}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
